// File: rtl/tick_rate_controller.sv
// Steps through the divider's 0.5 / 0.67 / 1 Hz timebases, emitting one step per
// accepted tick and advancing the rate level every STEPS_PER_LEVEL steps.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start, counters cleared
// S_RUN    | accepting ticks from the source selected by rate_sel
// S_PAUSED | ticks discarded, counters held, waiting for start with pause low
// S_DONE   | all three levels completed, final counts held
module tick_rate_controller #(
  parameter int STEPS_PER_LEVEL = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_067hz,
  input  logic             sq_05hz,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic             step,
  output logic [1:0]       rate_sel,
  output logic [CNT_W-1:0] level_steps,
  output logic [CNT_W+1:0] total_steps,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_LVL = CNT_W'(STEPS_PER_LEVEL - 1);

  state_t           state, state_nxt;
  logic             sq_prev;
  logic             tick_05;
  logic             sel_tick;
  logic             step_nxt;
  logic [1:0]       rate_nxt;
  logic [CNT_W-1:0] level_nxt;
  logic [CNT_W+1:0] total_nxt;

  assign tick_05 = sq_05hz & ~sq_prev;

  always_comb begin
    case (rate_sel)
      2'd0:    sel_tick = tick_05;
      2'd1:    sel_tick = tick_067hz;
      2'd2:    sel_tick = tick_1hz;
      default: sel_tick = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = 1'b0;
    rate_nxt  = rate_sel;
    level_nxt = level_steps;
    total_nxt = total_steps;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          rate_nxt  = 2'd0;
          level_nxt = '0;
          total_nxt = '0;
        end
      end
      S_RUN: begin
        // pause beats a same-cycle tick; that tick is simply lost
        if (pause) begin
          state_nxt = S_PAUSED;
        end else if (sel_tick) begin
          step_nxt  = 1'b1;
          total_nxt = total_steps + (CNT_W+2)'(1);
          if (level_steps == LAST_LVL) begin
            level_nxt = '0;
            if (rate_sel < 2'd2) rate_nxt = rate_sel + 2'd1;
            else                 state_nxt = S_DONE;
          end else begin
            level_nxt = level_steps + CNT_W'(1);
          end
        end
      end
      S_PAUSED: begin
        if (start && !pause) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      step_nxt  = 1'b0;
      rate_nxt  = 2'd0;
      level_nxt = '0;
      total_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sq_prev     <= 1'b0;
      step        <= 1'b0;
      rate_sel    <= 2'd0;
      level_steps <= '0;
      total_steps <= '0;
    end else begin
      state       <= state_nxt;
      sq_prev     <= sq_05hz;
      step        <= step_nxt;
      rate_sel    <= rate_nxt;
      level_steps <= level_nxt;
      total_steps <= total_nxt;
    end
  end

  assign busy = (state == S_RUN) || (state == S_PAUSED);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_tick_rate_controller.sv
// Bench for tick_rate_controller: directed vector table, async reset sequence,
// and random stimulus against a step-count-based reference model.
module tb_tick_rate_controller;
  localparam int S  = 3;
  localparam int CW = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_067hz = 1'b0, sq_05hz = 1'b0;
  logic start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic step, busy, done;
  logic [1:0] rate_sel;
  logic [CW-1:0] level_steps;
  logic [CW+1:0] total_steps;

  tick_rate_controller #(.STEPS_PER_LEVEL(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_067hz(tick_067hz),
    .sq_05hz(sq_05hz), .start(start), .pause(pause), .abort(abort),
    .step(step), .rate_sel(rate_sel), .level_steps(level_steps),
    .total_steps(total_steps), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: the whole run is described by how many steps have been taken so far;
  // level and count-within-level follow from plain division.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_mode, m_n;
  bit m_prev, m_step;

  function automatic void m_reset();
    m_mode = M_IDLE; m_n = 0; m_prev = 1'b0; m_step = 1'b0;
  endfunction

  function automatic int m_rate();
    return (m_n >= 3*S) ? 2 : m_n / S;
  endfunction

  function automatic int m_level();
    return (m_n >= 3*S) ? 0 : m_n % S;
  endfunction

  function automatic void m_update(bit st, bit pa, bit ab, bit t1, bit t067, bit sq);
    int r;
    bit tk, acc;
    r   = m_rate();
    tk  = (r == 0) ? (sq && !m_prev) : (r == 1) ? t067 : t1;
    acc = (m_mode == M_RUN) && !ab && !pa && tk;
    m_step = acc;
    if (ab) begin
      m_mode = M_IDLE; m_n = 0;
    end else if ((m_mode == M_IDLE || m_mode == M_DONE) && st) begin
      m_mode = M_RUN; m_n = 0;
    end else if (m_mode == M_RUN && pa) begin
      m_mode = M_PAUSED;
    end else if (acc) begin
      m_n++;
      if (m_n == 3*S) m_mode = M_DONE;
    end else if (m_mode == M_PAUSED && st && !pa) begin
      m_mode = M_RUN;
    end
    m_prev = sq;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_step"},  step,        m_step);
    chk({tag, "_rate"},  rate_sel,    m_rate());
    chk({tag, "_level"}, level_steps, m_level());
    chk({tag, "_total"}, total_steps, m_n);
    chk({tag, "_busy"},  busy,        (m_mode == M_RUN || m_mode == M_PAUSED));
    chk({tag, "_done"},  done,        (m_mode == M_DONE));
  endtask

  // Called at posedge+1: drive inputs, advance the model, then step one edge.
  task automatic cyc(input bit st, input bit pa, input bit ab,
                     input bit t1, input bit t067, input bit sq);
    start = st; pause = pa; abort = ab;
    tick_1hz = t1; tick_067hz = t067; sq_05hz = sq;
    m_update(st, pa, ab, t1, t067, sq);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit st, pa, ab, t1, t067, sq;
    bit e_step;
    int e_rate, e_lvl, e_tot;
    bit e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit pa, bit ab, bit t1, bit t067, bit sq,
                              bit es, int er, int el, int et, bit eb, bit ed);
    vec_t v;
    v.st = st; v.pa = pa; v.ab = ab; v.t1 = t1; v.t067 = t067; v.sq = sq;
    v.e_step = es; v.e_rate = er; v.e_lvl = el; v.e_tot = et;
    v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  initial begin
    //                st pa ab t1 t67 sq   stp rt lv tot bsy dn
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    1, 0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    1, 1, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    0, 1, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    0, 1, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,    1, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 1, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,    1, 1, 2, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 1, 2, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,    1, 2, 0, 6, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 2, 0, 6, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    1, 2, 1, 7, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 2, 1, 7, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    1, 2, 2, 8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 2, 2, 8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,    1, 2, 0, 9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,    0, 2, 0, 9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    0, 2, 0, 9, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    1, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,    1, 0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,    0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,    0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,    0, 0, 2, 2, 1, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0,    0, 0, 0, 0, 0, 0));

    m_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_step", step, 0);
    chk("reset_rate", rate_sel, 0);
    chk("reset_level", level_steps, 0);
    chk("reset_total", total_steps, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].pa, tbl[i].ab, tbl[i].t1, tbl[i].t067, tbl[i].sq);
      chk($sformatf("vec%0d_step", i),  step,        tbl[i].e_step);
      chk($sformatf("vec%0d_rate", i),  rate_sel,    tbl[i].e_rate);
      chk($sformatf("vec%0d_level", i), level_steps, tbl[i].e_lvl);
      chk($sformatf("vec%0d_total", i), total_steps, tbl[i].e_tot);
      chk($sformatf("vec%0d_busy", i),  busy,        tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i),  done,        tbl[i].e_done);
    end

    // async reset in the middle of level 1
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < S; k++) begin
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk_model("pre_rst");
    chk("pre_rst_level_is_1", rate_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_step", step, 0);
    chk("arst_rate", rate_sel, 0);
    chk("arst_level", level_steps, 0);
    chk("arst_total", total_steps, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, k[0], k[1], k[0]);
      chk_model($sformatf("post_rst%0d", k));
    end

    // random phase
    begin
      bit sq_r, pa_r;
      sq_r = 1'b0; pa_r = 1'b0;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 5) == 0)  sq_r = ~sq_r;
        if ($urandom_range(0, 39) == 0) pa_r = ~pa_r;
        cyc($urandom_range(0, 19) == 0, pa_r, $urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, sq_r);
        chk_model($sformatf("rnd%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_rate_controller.md
Name: tick_rate_controller

Overview:
- Sequences the clock divider's three timebase outputs into one stepped event stream whose rate escalates over a run: 0.5 Hz, then 0.67 Hz, then 1 Hz.
- Sits between clock_divider and the game/display logic. It selects which divider output is live, counts steps per level, advances the level, and reports completion.
- Supports start, pause, resume and abort control.
- Everything is synchronous to clk. Divider outputs are generated in the same clock domain, so no synchronisers are used.

Parameters:
- STEPS_PER_LEVEL, 8, number of steps emitted at each rate level before advancing; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the step counters.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- tick_1hz  in  1  single-cycle pulse from divider, 1 Hz
- tick_067hz  in  1  single-cycle pulse from divider, 0.67 Hz
- sq_05hz  in  1  0.5 Hz square wave from divider; rising edge is the tick
- start  in  1  level-sensitive; begin run from IDLE/DONE, or resume from PAUSED
- pause  in  1  level-sensitive; suspend stepping while in RUN
- abort  in  1  return to IDLE from any state
- step  out  1  single-cycle pulse, one per accepted tick of the selected rate
- rate_sel  out  2  current level: 0=0.5 Hz, 1=0.67 Hz, 2=1 Hz
- level_steps  out  CNT_W  steps emitted in current level
- total_steps  out  CNT_W+2  steps emitted in current run
- busy  out  1  high in RUN or PAUSED
- done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE; step=0; rate_sel=0; level_steps=0; total_steps=0; busy=0; done=0.
  - sq_05hz edge-detect register=0.
- Edge detect:
  - sq_prev <= sq_05hz every cycle, in every state.
  - tick_05 = sq_05hz & ~sq_prev.
- Selected tick: sel_tick = tick_05 when rate_sel=0, tick_067hz when 1, tick_1hz when 2. Ticks from non-selected sources are ignored.
- States:
  - IDLE -> RUN on start. Entering RUN clears rate_sel, level_steps, total_steps and done.
  - RUN -> PAUSED on pause (priority over a same-cycle sel_tick; that tick is dropped).
  - RUN: on sel_tick, step=1 in the next cycle (latency 1). On that same registered edge:
    - level_steps and total_steps increment.
    - If level_steps reaches STEPS_PER_LEVEL: level_steps <= 0. If rate_sel<2, rate_sel increments; else -> DONE.
  - PAUSED -> RUN on start with pause low. Counters are held. Ticks during PAUSED are discarded, not queued.
  - DONE: done=1, busy=0, counters hold final values (rate_sel=2, level_steps=0, total_steps=3*STEPS_PER_LEVEL). -> RUN on start (new run).
  - abort in any state -> IDLE next cycle, counters cleared, step=0. abort has priority over start, pause and sel_tick.
- Rate switch boundary: the first tick accepted at a new level is the first selected-source tick arriving strictly after the switch cycle. A pulse coinciding with the switch cycle is ignored.
- step is never high for two consecutive cycles.
- step is never high in IDLE or PAUSED, except the one-cycle registered pulse from a tick accepted on the cycle pause asserted. That case cannot occur, because pause wins.
- start held high in RUN has no effect.
- Counters never wrap within a run; total_steps width covers 3*(2^CNT_W-1).

Test Plan:
- Reset then start, STEPS_PER_LEVEL=3, bench drives sq_05hz edges every 10 cycles -> first step 1 cycle after each rising edge; after 3 steps rate_sel=1, level_steps=0, total_steps=3.
- At level 1, pulse tick_1hz and sq_05hz edges only -> no step; then pulse tick_067hz 3 times -> 3 steps, rate_sel=2, total_steps=6.
- Level 2: 3 tick_1hz pulses -> done=1, busy=0, total_steps=9, rate_sel=2; further ticks produce no step.
- Assert pause mid-level 0 after 1 step, send 4 ticks, deassert pause, pulse start -> no steps while paused; level_steps stays 1; next tick gives level_steps=2.
- tick and pause in same cycle -> no step, state PAUSED. abort and start in same cycle during RUN -> IDLE, all counters 0.
- Drop rst_n mid-run at level 1 -> all outputs at reset values immediately (async); after release, IDLE until start.
